// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - load/run/dump sequencer driving cpu enable and both external memory ports
module cpu_run_ctrl #(
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned RD_LAT    = 1,
  parameter logic [31:0] DUMP_BASE = 32'h0
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             start,
  input  logic [CNT_W-1:0] imem_words,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic [CNT_W-1:0] dump_words,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_data,
  input  logic             out_ready,
  output logic             cpu_enable,
  output logic [31:0]      addr_ext,
  output logic [31:0]      wdata_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      addr_ext_2,
  output logic [31:0]      wdata_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  input  logic [31:0]      rdata_ext_2,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_DUMP_RD, S_DUMP_OUT, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] imem_q, imem_d, run_q, run_d, dump_q, dump_d;
  logic [CNT_W-1:0] k_q, k_d, run_cnt_q, run_cnt_d;
  logic [1:0]       lat_q, lat_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [31:0]      k_addr;

  assign k_addr      = 32'(k_q) * 32'(ADDR_STEP);
  assign out_data    = out_data_q;
  assign ren_ext     = 1'b0;
  assign wen_ext_2   = 1'b0;
  assign wdata_ext_2 = 32'h0;

  // Phase that follows program load: skip any phase whose count is zero.
  function automatic state_t after_load(input logic [CNT_W-1:0] run, input logic [CNT_W-1:0] dump);
    if (run != '0)       return S_RUN;
    else if (dump != '0) return S_DUMP_RD;
    else                 return S_DONE;
  endfunction

  always_ff @(posedge clk) begin
    if (srst) begin
      state      <= S_IDLE;
      imem_q     <= '0;
      run_q      <= '0;
      dump_q     <= '0;
      k_q        <= '0;
      run_cnt_q  <= '0;
      lat_q      <= '0;
      out_data_q <= '0;
    end else begin
      state      <= state_n;
      imem_q     <= imem_d;
      run_q      <= run_d;
      dump_q     <= dump_d;
      k_q        <= k_d;
      run_cnt_q  <= run_cnt_d;
      lat_q      <= lat_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    state_n    = state;
    imem_d     = imem_q;
    run_d      = run_q;
    dump_d     = dump_q;
    k_d        = k_q;
    run_cnt_d  = run_cnt_q;
    lat_d      = lat_q;
    out_data_d = out_data_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    cpu_enable = 1'b0;
    addr_ext   = 32'h0;
    wdata_ext  = 32'h0;
    wen_ext    = 1'b0;
    addr_ext_2 = 32'h0;
    ren_ext_2  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (start) begin
          imem_d    = imem_words;
          run_d     = run_cycles;
          dump_d    = dump_words;
          k_d       = '0;
          run_cnt_d = run_cycles;
          lat_d     = 2'd0;
          state_n   = (imem_words != '0) ? S_LOAD : after_load(run_cycles, dump_words);
        end
      end
      S_LOAD: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          wen_ext   = 1'b1;
          addr_ext  = k_addr;
          wdata_ext = in_data;
          if (k_q == imem_q - CNT_ONE) begin
            k_d       = '0;
            run_cnt_d = run_q;
            lat_d     = 2'd0;
            state_n   = after_load(run_q, dump_q);
          end else begin
            k_d = k_q + CNT_ONE;
          end
        end
      end
      S_RUN: begin
        busy       = 1'b1;
        cpu_enable = 1'b1;
        run_cnt_d  = run_cnt_q - CNT_ONE;
        lat_d      = 2'd0;
        if (run_cnt_q == CNT_ONE) state_n = (dump_q != '0) ? S_DUMP_RD : S_DONE;
      end
      S_DUMP_RD: begin
        // Read strobe on the first cycle only; address held while the memory responds.
        busy       = 1'b1;
        addr_ext_2 = DUMP_BASE + k_addr;
        ren_ext_2  = (lat_q == 2'd0);
        if (lat_q == 2'(RD_LAT)) begin
          out_data_d = rdata_ext_2;
          state_n    = S_DUMP_OUT;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_DUMP_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          lat_d = 2'd0;
          if (k_q == dump_q - CNT_ONE) begin
            k_d     = '0;
            state_n = S_DONE;
          end else begin
            k_d     = k_q + CNT_ONE;
            state_n = S_DUMP_RD;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - self-checking bench for cpu_run_ctrl with memory models and scoreboards
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        srst, start;
  logic [15:0] imem_words, run_cycles, dump_words;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic        cpu_enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2, busy, done;
  logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;

  cpu_run_ctrl dut (
    .clk(clk), .srst(srst), .start(start),
    .imem_words(imem_words), .run_cycles(run_cycles), .dump_words(dump_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .cpu_enable(cpu_enable), .addr_ext(addr_ext), .wdata_ext(wdata_ext),
    .wen_ext(wen_ext), .ren_ext(ren_ext), .addr_ext_2(addr_ext_2),
    .wdata_ext_2(wdata_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .rdata_ext_2(rdata_ext_2), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Data memory with one cycle read latency; poison value when not reading.
  logic [31:0] dmem [0:63];
  always @(posedge clk) rdata_ext_2 <= ren_ext_2 ? dmem[addr_ext_2[7:2]] : 32'hdead_beef;

  int          cyc = 0, en_cnt = 0, en_runs = 0, viol = 0;
  logic        prev_en = 1'b0, prev_stall = 1'b0;
  logic [31:0] prev_od = 32'h0;
  logic [31:0] wr_a[$], wr_d[$], rd_a[$], od[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int v;
    v = 0;
    if (wen_ext) begin
      wr_a.push_back(addr_ext);
      wr_d.push_back(wdata_ext);
      if (!(in_valid && in_ready)) v++;
    end
    if (ren_ext_2) rd_a.push_back(addr_ext_2);
    if (out_valid && out_ready) od.push_back(out_data);
    if (cpu_enable && (wen_ext || ren_ext_2 || in_ready || out_valid)) v++;
    if (ren_ext || wen_ext_2 || wdata_ext_2 != 32'h0) v++;
    if (busy && done) v++;
    if (prev_stall && !srst && (!out_valid || out_data != prev_od)) v++;
    viol       <= viol + v;
    prev_stall <= out_valid && !out_ready;
    prev_od    <= out_data;
    prev_en    <= cpu_enable;
    en_cnt     <= en_cnt + (cpu_enable ? 1 : 0);
    if (cpu_enable && !prev_en) en_runs <= en_runs + 1;
  end

  int          total = 0, bad = 0;
  int          t0, wb, rb, ob, eb, erb, vb;
  logic [31:0] prog [0:15];

  typedef struct { int ni; int nr; int nd; int lat; } vec_t;
  vec_t tbl [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    srst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    imem_words = 16'h0; run_cycles = 16'h0; dump_words = 16'h0;
    tick; tick;
    srst = 1'b0;
  endtask

  task automatic start_seq(input int ni, input int nr, input int nd);
    wb = wr_a.size(); rb = rd_a.size(); ob = od.size();
    eb = en_cnt; erb = en_runs; vb = viol;
    start = 1'b1;
    imem_words = 16'(ni); run_cycles = 16'(nr); dump_words = 16'(nd);
    tick;
    start = 1'b0;
    imem_words = 16'($urandom); run_cycles = 16'($urandom); dump_words = 16'($urandom);
    t0 = cyc;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    int n;
    repeat (gap) begin in_valid = 1'b0; tick; end
    in_valid = 1'b1; in_data = w; n = 0;
    while (!in_ready && n < 50) begin tick; n++; end
    tick;
    in_valid = 1'b0; in_data = $urandom;
  endtask

  task automatic wait_done(input int pct, output int lat, output bit ok);
    int n;
    n = 0;
    out_ready = ($urandom_range(99, 0) < pct);
    while (!done && n < 3000) begin
      tick; n++;
      out_ready = ($urandom_range(99, 0) < pct);
    end
    ok = done;
    lat = cyc - t0;
    out_ready = 1'b0;
  endtask

  task automatic score(input int ni, input int nr, input int nd, input string tag);
    check({tag, "_nwr"}, 32'(wr_a.size() - wb), 32'(ni));
    for (int i = 0; i < ni && wb + i < wr_a.size(); i++) begin
      check({tag, "_wr_addr"}, wr_a[wb + i], 32'(i * 4));
      check({tag, "_wr_data"}, wr_d[wb + i], prog[i]);
    end
    check({tag, "_nren"}, 32'(rd_a.size() - rb), 32'(nd));
    for (int i = 0; i < nd && rb + i < rd_a.size(); i++)
      check({tag, "_ren_addr"}, rd_a[rb + i], 32'(i * 4));
    check({tag, "_nout"}, 32'(od.size() - ob), 32'(nd));
    for (int i = 0; i < nd && ob + i < od.size(); i++)
      check({tag, "_out_data"}, od[ob + i], dmem[i]);
    check({tag, "_en_cycles"}, 32'(en_cnt - eb), 32'(nr));
    check({tag, "_en_runs"}, 32'(en_runs - erb), 32'(nr != 0));
    check({tag, "_protocol"}, 32'(viol - vb), 32'h0);
  endtask

  task automatic fill_mems;
    for (int i = 0; i < 16; i++) prog[i] = $urandom;
    for (int i = 0; i < 64; i++) dmem[i] = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat, n, ebx;
    bit  ok;
    int  ni, nr, nd;

    // {imem_words, run_cycles, dump_words, cycles from start+1 to done}
    tbl[0] = '{0, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 1};
    tbl[2] = '{0, 1, 0, 1};
    tbl[3] = '{0, 0, 1, 3};
    tbl[4] = '{2, 3, 2, 11};
    tbl[5] = '{4, 1, 0, 5};
    tbl[6] = '{0, 5, 3, 14};
    tbl[7] = '{3, 0, 2, 9};

    fill_mems;
    do_reset;
    check("reset_outputs",
          32'({in_ready, out_valid, cpu_enable, wen_ext, ren_ext_2, busy, done,
               |out_data, |addr_ext, |wdata_ext, |addr_ext_2}), 32'h0);

    for (int r = 0; r < 8; r++) begin
      fill_mems;
      start_seq(tbl[r].ni, tbl[r].nr, tbl[r].nd);
      for (int i = 0; i < tbl[r].ni; i++) send_word(prog[i], 0);
      wait_done(100, lat, ok);
      check("tbl_done", 32'(ok), 32'h1);
      check("tbl_latency", 32'(lat), 32'(tbl[r].lat));
      score(tbl[r].ni, tbl[r].nr, tbl[r].nd, "tbl");
    end

    // Gapped load, 7-cycle run, dump with backpressure on the first word.
    fill_mems;
    prog[0] = 32'h2001_0005; prog[1] = 32'h2002_0007; prog[2] = 32'h0022_1820;
    dmem[0] = 32'h11; dmem[1] = 32'h22;
    start_seq(3, 7, 2);
    for (int i = 0; i < 3; i++) send_word(prog[i], 1);
    check("in_ready_drop", 32'(in_ready), 32'h0);
    n = 0;
    while (!out_valid && n < 100) begin tick; n++; end
    check("dump_valid0", 32'(out_valid), 32'h1);
    for (int i = 0; i < 3; i++) begin
      check("dump_stall_data", out_data, 32'h11);
      tick;
    end
    out_ready = 1'b1;
    tick;
    n = 0;
    while (!out_valid && n < 100) begin tick; n++; end
    check("dump_data1", out_data, 32'h22);
    tick;
    out_ready = 1'b0;
    check("dump_done", 32'(done), 32'h1);
    score(3, 7, 2, "dir");

    // A second start during LOAD must not disturb the latched counts.
    fill_mems;
    start_seq(3, 2, 1);
    send_word(prog[0], 0);
    in_valid = 1'b0; start = 1'b1;
    imem_words = 16'd1; run_cycles = 16'd9; dump_words = 16'd4;
    tick;
    start = 1'b0;
    check("busy_start_busy", 32'(busy), 32'h1);
    send_word(prog[1], 0);
    send_word(prog[2], 0);
    wait_done(100, lat, ok);
    check("busy_done", 32'(ok), 32'h1);
    score(3, 2, 1, "busy");

    for (int it = 0; it < 25; it++) begin
      fill_mems;
      ni = $urandom_range(6, 0); nr = $urandom_range(12, 0); nd = $urandom_range(5, 0);
      start_seq(ni, nr, nd);
      for (int i = 0; i < ni; i++) send_word(prog[i], $urandom_range(2, 0));
      wait_done(60, lat, ok);
      check("rnd_done", 32'(ok), 32'h1);
      score(ni, nr, nd, "rnd");
    end

    // Reset in the middle of a long run.
    start_seq(0, 100, 0);
    repeat (5) tick;
    check("mid_run_enable", 32'(cpu_enable), 32'h1);
    srst = 1'b1;
    tick;
    check("mid_run_reset", 32'({cpu_enable, busy, done, wen_ext, ren_ext_2, in_ready, out_valid}), 32'h0);
    tick;
    srst = 1'b0;
    ebx = en_cnt;
    repeat (3) tick;
    check("post_reset_idle", 32'({busy, done, cpu_enable}), 32'h0);
    check("post_reset_no_enable", 32'(en_cnt - ebx), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Test-and-run sequencer for the pipelined cpu.
- Streams a program into instruction memory through the cpu's external port (addr_ext/wen_ext/wdata_ext), then holds cpu enable high for a programmed number of cycles.
- Then reads a programmed window of data memory back through addr_ext_2/ren_ext_2 and streams it out.
- Sits between the bench/host interface and the cpu top; it is the only driver of cpu enable and of both external memory ports.

Parameters:
- ADDR_STEP, 4, address increment per word on both external ports (byte addressing).
- CNT_W, 16, width of the word-count and cycle-count inputs.
- RD_LAT, 1, cycles from ren_ext_2 assertion to valid rdata_ext_2 (1..3).
- DUMP_BASE, 0, first data-memory address read during dump.

Ports:
- clk  in  1  clock; all logic on rising edge.
- srst  in  1  synchronous active-high reset.
- start  in  1  single-cycle pulse; starts a sequence from IDLE/DONE, ignored otherwise.
- imem_words  in  CNT_W  number of program words to load; sampled at start.
- run_cycles  in  CNT_W  number of enabled cpu cycles; sampled at start.
- dump_words  in  CNT_W  number of data words to read back; sampled at start.
- in_valid  in  1  program word valid.
- in_data  in  32  program word.
- in_ready  out  1  controller accepts in_data this cycle.
- out_valid  out  1  dump word valid.
- out_data  out  32  dump word.
- out_ready  in  1  sink accepts out_data.
- cpu_enable  out  1  to cpu enable.
- addr_ext, wdata_ext  out  32  instruction memory external address / write data.
- wen_ext, ren_ext  out  1  instruction memory external write / read enable (ren_ext tied 0).
- addr_ext_2, wdata_ext_2  out  32  data memory external address / write data (wdata_ext_2 tied 0).
- wen_ext_2, ren_ext_2  out  1  data memory external write enable (tied 0) / read enable.
- rdata_ext_2  in  32  data memory read data.
- busy  out  1  high in LOAD, RUN, DUMP_RD, DUMP_OUT.
- done  out  1  high in DONE.

Behaviour:
- Reset (srst high at edge): state=IDLE, all counters 0, every output 0 (in_ready, out_valid, out_data, cpu_enable, all addr/data/enable lines, busy, done).
- States: IDLE, LOAD, RUN, DUMP_RD, DUMP_OUT, DONE.
- IDLE/DONE + start: latch the three counts, word index k=0, then go to:
  - LOAD if imem_words!=0;
  - else RUN if run_cycles!=0;
  - else DUMP_RD if dump_words!=0;
  - else DONE.
- LOAD:
  - in_ready=1.
  - A transfer occurs when in_valid&in_ready. In that same cycle, combinationally: wen_ext=1, addr_ext=k*ADDR_STEP, wdata_ext=in_data.
  - k increments per transfer.
  - On the transfer with k=imem_words-1, the next state follows the same skip rules as start (RUN, else DUMP_RD, else DONE) and k resets to 0.
  - No write occurs without in_valid. cpu_enable=0 throughout.
- RUN:
  - cpu_enable=1 for exactly run_cycles consecutive cycles, counted by a down-counter.
  - Then cpu_enable drops and the state moves to DUMP_RD (or DONE if dump_words=0).
  - The pipeline is frozen, not flushed, on exit.
- DUMP_RD:
  - ren_ext_2=1 and addr_ext_2=DUMP_BASE+k*ADDR_STEP for one cycle.
  - Wait RD_LAT cycles (ren low, address held).
  - Capture rdata_ext_2 into out_data, then go to DUMP_OUT.
- DUMP_OUT:
  - out_valid=1, out_data stable until out_ready.
  - On handshake, k increments: back to DUMP_RD, or DONE after word dump_words-1.
  - out_valid may not drop without a handshake.
- DONE: done=1, busy=0; stays until start or srst.
- start while busy: ignored; latched counts are unchanged.
- srst mid-sequence: immediate return to IDLE next edge.
  - cpu_enable and all write enables are 0 in the cycle after reset.
  - A partially loaded program is left as-is.
- Counter arithmetic is CNT_W bits. Addresses are 32-bit, computed as k*ADDR_STEP with zero-extended k; wrap-around is not checked.
- Maximum throughput:
  - load: 1 word/cycle;
  - dump: 1 word per RD_LAT+2 cycles.

Test Plan:
- Reset: srst for 2 cycles mid-RUN (run_cycles=100) -> next cycle state IDLE, cpu_enable=0, busy=0, done=0, all wen 0.
- Load with gaps: imem_words=3, words 0x20010005,0x20020007,0x00221820 with in_valid low 1 cycle between each -> exactly three wen_ext pulses at addr 0,4,8 with matching data; in_ready drops after the third.
- Run length: run_cycles=7 -> cpu_enable high exactly 7 consecutive cycles, then low; program above leaves data memory unchanged.
- Dump backpressure: dump_words=2, data memory words 0x11,0x22 at 0,4, out_ready low 3 cycles on first word -> out_data=0x11 held stable while out_valid high, then 0x22; ren_ext_2 pulses at addr 0 then 4; done follows.
- Zero counts: imem_words=0, run_cycles=0, dump_words=0, start -> DONE one cycle later, no enables asserted.
- Start while busy: second start during LOAD with different counts -> ignored; original counts completed.
